stream_raw_sequencer: RTL and testbench
=======================================

STREAM_RAW_SEQUENCER -- requirements
Module: stream_raw_sequencer

Interface
REQ-001 SHALL have parameter AN, default 8: address width; the scoreboard depth is 2^AN.
REQ-002 SHALL have parameter DN, default 8: data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports iWA, iWA_valid, iWA_ready: input write-address stream, AN bits.
REQ-006 SHALL have ports iW, iW_valid, iW_ready: input write-data stream, DN bits.
REQ-007 SHALL have ports iRA, iRA_valid, iRA_ready: input read-address stream, AN bits.
REQ-008 SHALL have ports sWA, sWA_valid, sWA_ready: output write-address stream, AN bits.
REQ-009 SHALL have ports sW, sW_valid, sW_ready: output write-data stream, DN bits.
REQ-010 SHALL have ports sRA, sRA_valid, sRA_ready: output read-address stream, AN bits, feeding the array read/write stage.
REQ-011 SHALL have port clear, input, 1 bit: single-cycle pulse requesting a scoreboard flush.
REQ-012 SHALL have port busy, output, 1 bit: high in states DRAIN and CLEAR.

Function
REQ-013 SHALL keep a scoreboard of 2^AN bits, one per address; bit set = address written.
REQ-014 SHALL accept a write only when iWA_valid and iW_valid are both high and the write output slot is empty or being drained in the same cycle; iWA_ready and iW_ready SHALL be equal.
REQ-015 SHALL register each accepted write into single-entry output registers; sWA_valid and sW_valid SHALL be equal; latency from input to output SHALL be 1 cycle.
REQ-016 SHALL hold sWA/sW stable until sWA_ready and sW_ready are both high.
REQ-017 SHALL set scoreboard[sWA] on the output write handshake edge.
REQ-018 SHALL accept iRA only when scoreboard[iRA] is already set (not set in the same cycle) and the read output slot is free; otherwise iRA_ready SHALL be low.
REQ-019 Consequence of REQ-017/018: a read of address A SHALL reach sRA no earlier than 2 cycles after A's output write handshake.
REQ-020 SHALL register each accepted read into sRA with 1-cycle latency and hold it until sRA_ready.
REQ-021 Reads and writes SHALL proceed independently in the same cycle; order is preserved within each stream.
REQ-022 SHALL implement FSM RUN, DRAIN, CLEAR; reset state RUN.
REQ-023 In RUN, clear SHALL go to DRAIN; inputs SHALL be blocked from the following cycle.
REQ-024 In DRAIN, all input ready signals SHALL be low; when both output slots are empty, the FSM SHALL go to CLEAR.
REQ-025 CLEAR SHALL zero the entire scoreboard in one cycle and then go to RUN.
REQ-026 clear SHALL be ignored outside RUN.
REQ-027 A read whose address is never written SHALL stall indefinitely; this is not an error.

Reset
REQ-028 While nrst is low, all *_valid outputs SHALL be 0, busy SHALL be 0, sWA/sW/sRA SHALL be 0, the scoreboard SHALL be all 0, and the FSM SHALL be in RUN.
REQ-029 Reset asserted mid-transfer SHALL discard held outputs without completing them.

Configuration
REQ-030 With RAW_SEQ_STATS_EN defined, the block SHALL add output stall_cnt (16 bits), counting cycles with iRA_valid high and iRA_ready low; it SHALL saturate at 16'hFFFF and reset to 0 on nrst or in CLEAR.
REQ-031 Without RAW_SEQ_STATS_EN, stall_cnt SHALL not exist and behaviour SHALL otherwise be identical.

Verification
REQ-032 Write addresses 0..254 with data (i*7)&8'h7f, then read 0..254 -> sRA emits 0..254 in order; no read precedes its write handshake by fewer than 2 cycles.
REQ-033 Hold iRA=5 valid before any write, then write addr 5 -> iRA_ready stays low until 2 cycles after the sWA handshake on 5.
REQ-034 Hold sWA_ready=0 for 10 cycles with iWA=3, iW=9 -> sWA=3 and sW=9 held stable, iWA_ready=0 on the second write, no data lost.
REQ-035 Write addr 7, pulse clear, then request read of 7 -> busy high for DRAIN+CLEAR; after return to RUN, read 7 stalls until 7 is rewritten.
REQ-036 Assert nrst low with sRA_valid=1 -> all valids drop asynchronously; after release, earlier-written addresses stall on read.
REQ-037 With RAW_SEQ_STATS_EN, an unwritten read held for 20 cycles -> stall_cnt=20; after clear, stall_cnt=0.

Source files
------------

// File: rtl/stream_raw_sequencer.sv
// Read-after-write sequencer: writes pass through a 1-entry slot and mark a
// per-address scoreboard; reads are released only for already-written addresses.
// Optional stall statistics counter enabled by defining RAW_SEQ_STATS_EN.
module stream_raw_sequencer #(
  parameter int AN = 8,
  parameter int DN = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [AN-1:0] iWA,
  input  logic          iWA_valid,
  output logic          iWA_ready,
  input  logic [DN-1:0] iW,
  input  logic          iW_valid,
  output logic          iW_ready,
  input  logic [AN-1:0] iRA,
  input  logic          iRA_valid,
  output logic          iRA_ready,
  output logic [AN-1:0] sWA,
  output logic          sWA_valid,
  input  logic          sWA_ready,
  output logic [DN-1:0] sW,
  output logic          sW_valid,
  input  logic          sW_ready,
  output logic [AN-1:0] sRA,
  output logic          sRA_valid,
  input  logic          sRA_ready,
  input  logic          clear,
`ifdef RAW_SEQ_STATS_EN
  output logic [15:0]   stall_cnt,
`endif
  output logic          busy
);

  localparam int DEPTH = 1 << AN;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_CLEAR} state_t;

  state_t            r_state, w_state_nxt;
  logic [DEPTH-1:0]  r_sb;
  logic [AN-1:0]     r_wa, r_ra;
  logic [DN-1:0]     r_w;
  logic              r_wvld, r_rvld;

  logic w_run, w_wr_hs, w_wr_acc, w_rd_hs, w_rd_slot, w_rd_acc;

  assign w_run     = (r_state == S_RUN);
  assign w_wr_hs   = r_wvld & sWA_ready & sW_ready;
  // Both input streams must be valid together, so ready includes the valids
  // to avoid handing off one half of a write.
  assign w_wr_acc  = w_run & iWA_valid & iW_valid & (~r_wvld | w_wr_hs);
  assign w_rd_hs   = r_rvld & sRA_ready;
  assign w_rd_slot = ~r_rvld | w_rd_hs;
  // Registered scoreboard only: a bit set on this edge is visible next cycle.
  assign w_rd_acc  = w_run & iRA_valid & r_sb[iRA] & w_rd_slot;

  assign iWA_ready = w_wr_acc;
  assign iW_ready  = w_wr_acc;
  assign iRA_ready = w_run & r_sb[iRA] & w_rd_slot;

  assign sWA       = r_wa;
  assign sW        = r_w;
  assign sWA_valid = r_wvld;
  assign sW_valid  = r_wvld;
  assign sRA       = r_ra;
  assign sRA_valid = r_rvld;
  assign busy      = ~w_run;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (clear) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_wvld && !r_rvld) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                  r_sb <= '0;
    else if (r_state == S_CLEAR) r_sb <= '0;
    else if (w_wr_hs)           r_sb[r_wa] <= 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wa   <= '0;
      r_w    <= '0;
      r_wvld <= 1'b0;
    end else if (w_wr_acc) begin
      r_wa   <= iWA;
      r_w    <= iW;
      r_wvld <= 1'b1;
    end else if (w_wr_hs) begin
      r_wvld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ra   <= '0;
      r_rvld <= 1'b0;
    end else if (w_rd_acc) begin
      r_ra   <= iRA;
      r_rvld <= 1'b1;
    end else if (w_rd_hs) begin
      r_rvld <= 1'b0;
    end
  end

`ifdef RAW_SEQ_STATS_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                  r_stall <= '0;
    else if (r_state == S_CLEAR)                r_stall <= '0;
    else if (iRA_valid && !iRA_ready && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end

  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_stream_raw_sequencer.sv
// Directed bench for stream_raw_sequencer: RAW ordering, backpressure, clear
// flush, async reset and (when RAW_SEQ_STATS_EN is defined) the stall counter.
module tb_stream_raw_sequencer;
  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] iWA, iW, iRA, sWA, sW, sRA;
  logic       iWA_valid, iWA_ready, iW_valid, iW_ready, iRA_valid, iRA_ready;
  logic       sWA_valid, sWA_ready, sW_valid, sW_ready, sRA_valid, sRA_ready;
  logic       clear, busy;
`ifdef RAW_SEQ_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  stream_raw_sequencer #(.AN(8), .DN(8)) dut (
    .clk(clk), .nrst(nrst),
    .iWA(iWA), .iWA_valid(iWA_valid), .iWA_ready(iWA_ready),
    .iW(iW), .iW_valid(iW_valid), .iW_ready(iW_ready),
    .iRA(iRA), .iRA_valid(iRA_valid), .iRA_ready(iRA_ready),
    .sWA(sWA), .sWA_valid(sWA_valid), .sWA_ready(sWA_ready),
    .sW(sW), .sW_valid(sW_valid), .sW_ready(sW_ready),
    .sRA(sRA), .sRA_valid(sRA_valid), .sRA_ready(sRA_ready),
    .clear(clear),
`ifdef RAW_SEQ_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_drive(input logic [7:0] a, input logic [7:0] d);
    iWA = a; iW = d; iWA_valid = 1'b1; iW_valid = 1'b1;
  endtask

  task automatic wr_idle;
    iWA_valid = 1'b0; iW_valid = 1'b0;
  endtask

  initial begin
    int bad;
    nrst = 1'b0; clear = 1'b0;
    iWA = '0; iW = '0; iRA = '0;
    iWA_valid = 1'b0; iW_valid = 1'b0; iRA_valid = 1'b0;
    sWA_ready = 1'b1; sW_ready = 1'b1; sRA_ready = 1'b1;
    #2;
    // reset state
    chk("rst_sWA_valid", 32'(sWA_valid), 32'd0);
    chk("rst_sW_valid",  32'(sW_valid),  32'd0);
    chk("rst_sRA_valid", 32'(sRA_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_data", {8'd0, sWA, sW, sRA}, 32'd0);
    #10 nrst = 1'b1;
    tick;

    // read of 5 before any write stalls; released the cycle after write handshake
    iRA = 8'd5; iRA_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin #1; if (iRA_ready !== 1'b0) bad++; tick; end
    chk("raw_early_stall", 32'(bad), 32'd0);
    wr_drive(8'd5, 8'h11);
    #1 chk("raw_wr_ready", 32'(iWA_ready & iW_ready), 32'd1);
    tick; wr_idle;
    chk("raw_sWA", {15'd0, sWA_valid, sW_valid, sWA, sW[6:0]}, {15'd0, 1'b1, 1'b1, 8'd5, 7'h11});
    #1 chk("raw_hs_cycle_ready", 32'(iRA_ready), 32'd0);
    tick;
    chk("raw_after_hs_ready", 32'(iRA_ready), 32'd1);
    chk("raw_no_sRA_yet", 32'(sRA_valid), 32'd0);
    tick; iRA_valid = 1'b0;
    chk("raw_sRA", {23'd0, sRA_valid, sRA}, {23'd0, 1'b1, 8'd5});
    tick;
    chk("raw_sRA_drained", 32'(sRA_valid), 32'd0);

    // write backpressure: hold 3/9, second write blocked, nothing lost
    sWA_ready = 1'b0; sW_ready = 1'b0;
    wr_drive(8'd3, 8'd9);
    tick;
    wr_drive(8'd4, 8'd10);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (iWA_ready !== 1'b0 || iW_ready !== 1'b0) bad++;
      if (sWA !== 8'd3 || sW !== 8'd9 || sWA_valid !== 1'b1 || sW_valid !== 1'b1) bad++;
      tick;
    end
    chk("bp_hold_stable", 32'(bad), 32'd0);
    sWA_ready = 1'b1; sW_ready = 1'b1;
    #1 chk("bp_ready_on_drain", 32'(iWA_ready), 32'd1);
    tick; wr_idle;
    chk("bp_second_write", {16'd0, sWA, sW}, {16'd0, 8'd4, 8'd10});
    tick;
    chk("bp_empty", 32'(sWA_valid), 32'd0);
    iRA = 8'd3; iRA_valid = 1'b1;
    #1 chk("bp_rd3_ready", 32'(iRA_ready), 32'd1);
    tick; iRA = 8'd4;
    chk("bp_rd3", 32'(sRA), 32'd3);
    tick; iRA_valid = 1'b0;
    chk("bp_rd4", {23'd0, sRA_valid, sRA}, {23'd0, 1'b1, 8'd4});
    tick;

    // stream writes 0..254 then reads 0..254
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      wr_drive(8'(i), 8'((i * 7) & 8'h7f));
      #1 if (iWA_ready !== 1'b1) bad++;
      tick;
      if (sWA_valid !== 1'b1 || sWA !== 8'(i) || sW !== 8'((i * 7) & 8'h7f)) bad++;
    end
    wr_idle;
    chk("stream_writes", 32'(bad), 32'd0);
    tick;
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      iRA = 8'(i); iRA_valid = 1'b1;
      #1 if (iRA_ready !== 1'b1) bad++;
      tick;
      if (sRA_valid !== 1'b1 || sRA !== 8'(i)) bad++;
    end
    iRA_valid = 1'b0;
    chk("stream_reads_in_order", 32'(bad), 32'd0);
    tick;

    // clear flush: busy through DRAIN and CLEAR, then 7 stalls until rewritten
    wr_drive(8'd7, 8'd1);
    tick; wr_idle;
    tick;
    clear = 1'b1;
    #1 chk("clr_busy_run", 32'(busy), 32'd0);
    tick; clear = 1'b0;
    iRA = 8'd7; iRA_valid = 1'b1;
    #1 chk("clr_drain", {30'd0, busy, iRA_ready}, {30'd0, 1'b1, 1'b0});
    tick;
    chk("clr_clear", {30'd0, busy, iRA_ready}, {30'd0, 1'b1, 1'b0});
    tick;
    chk("clr_back_run_busy", 32'(busy), 32'd0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin #1; if (iRA_ready !== 1'b0) bad++; tick; end
    chk("clr_rd7_stalls", 32'(bad), 32'd0);
    wr_drive(8'd7, 8'd2);
    tick; wr_idle;
    chk("clr_rd7_hs_cycle", 32'(iRA_ready), 32'd0);
    tick;
    chk("clr_rd7_released", 32'(iRA_ready), 32'd1);
    tick; iRA_valid = 1'b0;
    chk("clr_rd7_out", {23'd0, sRA_valid, sRA}, {23'd0, 1'b1, 8'd7});
    tick;

    // async reset with held outputs
    wr_drive(8'd12, 8'd5);
    tick; wr_idle;
    tick;
    sRA_ready = 1'b0; sWA_ready = 1'b0; sW_ready = 1'b0;
    iRA = 8'd12; iRA_valid = 1'b1;
    wr_drive(8'd13, 8'd6);
    tick; iRA_valid = 1'b0; wr_idle;
    chk("ar_held", {30'd0, sRA_valid, sWA_valid}, {30'd0, 1'b1, 1'b1});
    #2 nrst = 1'b0;
    #1 chk("ar_valids_drop", {29'd0, sRA_valid, sWA_valid, sW_valid}, 32'd0);
    chk("ar_data_zero", {8'd0, sWA, sW, sRA}, 32'd0);
    sRA_ready = 1'b1; sWA_ready = 1'b1; sW_ready = 1'b1;
    #1 nrst = 1'b1;
    tick;
    iRA = 8'd12; iRA_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin #1; if (iRA_ready !== 1'b0) bad++; tick; end
    chk("ar_rd12_stalls", 32'(bad), 32'd0);
    iRA_valid = 1'b0;

`ifdef RAW_SEQ_STATS_EN
    nrst = 1'b0; #2 nrst = 1'b1;
    tick;
    iRA = 8'd9; iRA_valid = 1'b1;
    for (int k = 0; k < 20; k++) tick;
    iRA_valid = 1'b0;
    chk("stats_20", 32'(stall_cnt), 32'd20);
    clear = 1'b1;
    tick; clear = 1'b0;
    tick;
    tick;
    chk("stats_cleared", 32'(stall_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
